// File: rtl/mips_mmio_port_responder.sv
// MMIO responder on the MIPS data-memory bus: latched output port, synchronized input
// port with change detection, and a down-counting timer with an expiry event.
module mips_mmio_port_responder #(
    parameter int unsigned      NBits     = 32,
    parameter logic [NBits-1:0] BASE_ADDR = 32'h1001_0100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [NBits-1:0] Address,
    input  logic [NBits-1:0] WriteData,
    input  logic [7:0]       PortIn,
    output logic             Select,
    output logic [NBits-1:0] ReadData,
    output logic [NBits-1:0] PortOut,
    output logic             Event
);

    localparam logic [2:0] RegPortOut  = 3'd0;
    localparam logic [2:0] RegPortIn   = 3'd1;
    localparam logic [2:0] RegStatus   = 3'd2;
    localparam logic [2:0] RegTmrLoad  = 3'd3;
    localparam logic [2:0] RegTmrCtrl  = 3'd4;
    localparam logic [2:0] RegTmrCount = 3'd5;

    logic [NBits-1:0] portOutReg, tmrLoad, cnt, cntNext, offset;
    logic [3:0]       tmrCtrl, ctrlNext;
    logic [1:0]       status, statusNext;
    logic [7:0]       sync1, sync2, prev;
    logic             eventReg, eventNext;
    logic [2:0]       regIdx;
    logic             wrEn, inChgSet, tmrExpSet;

    assign offset = Address - BASE_ADDR;
    assign Select = offset < NBits'(32);
    assign regIdx = offset[4:2];
    assign wrEn   = Select && MemWrite;

    assign PortOut = portOutReg;
    assign Event   = eventReg;

    always_comb begin
        ReadData = '0;
        if (Select && MemRead) begin
            case (regIdx)
                RegPortOut:  ReadData = portOutReg;
                RegPortIn:   ReadData = {{(NBits-8){1'b0}}, sync2};
                RegStatus:   ReadData = {{(NBits-2){1'b0}}, status};
                RegTmrLoad:  ReadData = tmrLoad;
                RegTmrCtrl:  ReadData = {{(NBits-4){1'b0}}, tmrCtrl};
                RegTmrCount: ReadData = cnt;
                default:     ReadData = '0;
            endcase
        end
    end

    always_comb begin
        inChgSet  = sync2 != prev;
        tmrExpSet = tmrCtrl[0] && (cnt == '0);

        // Hardware sets are OR-ed in after the W1C so they win a same-cycle clear.
        statusNext = status;
        if (wrEn && regIdx == RegStatus) begin
            statusNext = status & ~WriteData[1:0];
        end
        statusNext = statusNext | {tmrExpSet, inChgSet};

        cntNext  = cnt;
        ctrlNext = tmrCtrl;
        if (tmrCtrl[0]) begin
            if (cnt != '0) begin
                cntNext = cnt - 1'b1;
            end else if (tmrCtrl[1]) begin
                cntNext = tmrLoad;
            end else begin
                ctrlNext[0] = 1'b0;
            end
        end
        if (wrEn && regIdx == RegTmrLoad) begin
            cntNext = WriteData;
        end
        if (wrEn && regIdx == RegTmrCtrl) begin
            ctrlNext = WriteData[3:0];
        end

        eventNext = (status[0] & tmrCtrl[2]) | (status[1] & tmrCtrl[3]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            portOutReg <= '0;
            tmrLoad    <= '0;
            tmrCtrl    <= '0;
            cnt        <= '0;
            status     <= '0;
            eventReg   <= 1'b0;
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
        end else begin
            if (wrEn && regIdx == RegPortOut) begin
                portOutReg <= WriteData;
            end
            if (wrEn && regIdx == RegTmrLoad) begin
                tmrLoad <= WriteData;
            end
            tmrCtrl  <= ctrlNext;
            cnt      <= cntNext;
            status   <= statusNext;
            eventReg <= eventNext;
            sync1    <= PortIn;
            sync2    <= sync1;
            prev     <= sync2;
        end
    end

endmodule

// File: tb/tb_mips_mmio_port_responder.sv
// Self-checking bench for mips_mmio_port_responder: vector table plus hand-written
// sequences for synchronizer latency, W1C priority and timer behaviour.
module tb_mips_mmio_port_responder;

    localparam logic [31:0] Base = 32'h1001_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead;
    logic [31:0] Address, WriteData;
    logic [7:0]  PortIn;
    logic        Select;
    logic [31:0] ReadData, PortOut;
    logic        Event;

    int checks = 0;
    int errors = 0;

    mips_mmio_port_responder #(
        .NBits    (32),
        .BASE_ADDR(Base)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Address  (Address),
        .WriteData(WriteData),
        .PortIn   (PortIn),
        .Select   (Select),
        .ReadData (ReadData),
        .PortOut  (PortOut),
        .Event    (Event)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end (got timeout, required finish)");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [31:0] off;
        logic [31:0] wdata;
        logic        expSel;
        logic [31:0] expRd;
    } vec_t;
    vec_t vecs[20];

    task automatic expectVal(input string n, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    task automatic compare(input logic [31:0] act);
        exp_t x;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got %h with no expectation queued", act);
        end else begin
            x = sbq.pop_front();
            if (act !== x.exp) begin
                errors++;
                $display("FAIL %s: got %h required %h", x.name, act, x.exp);
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        expectVal(n, e);
        compare(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string n, input logic [31:0] off, input logic [31:0] e);
        Address = Base + off;
        MemRead = 1'b1;
        expectVal(n, e);
        #1;
        compare(ReadData);
        MemRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        Address   = Base + off;
        WriteData = data;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        int  n;
        bit  found;

        vecs[0]  = '{"wr_portout_rdpre",  1'b1, 1'b1, 32'h00, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[1]  = '{"rd_portout",        1'b0, 1'b1, 32'h00, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{"wr_out_of_window",  1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0};
        vecs[3]  = '{"rd_portout_keep",   1'b0, 1'b1, 32'h00, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{"wr_tmr_load",       1'b1, 1'b0, 32'h0C, 32'h100,       1'b1, 32'h0};
        vecs[5]  = '{"rd_tmr_load",       1'b0, 1'b1, 32'h0C, 32'h0,         1'b1, 32'h100};
        vecs[6]  = '{"rd_tmr_count",      1'b0, 1'b1, 32'h14, 32'h0,         1'b1, 32'h100};
        vecs[7]  = '{"wr_tmr_ctrl_mask",  1'b1, 1'b0, 32'h10, 32'hFFFF_FFF4, 1'b1, 32'h0};
        vecs[8]  = '{"rd_tmr_ctrl",       1'b0, 1'b1, 32'h10, 32'h0,         1'b1, 32'h4};
        vecs[9]  = '{"wr_reserved18",     1'b1, 1'b0, 32'h18, 32'hAAAA_5555, 1'b1, 32'h0};
        vecs[10] = '{"rd_reserved18",     1'b0, 1'b1, 32'h18, 32'h0,         1'b1, 32'h0};
        vecs[11] = '{"rd_reserved1c",     1'b0, 1'b1, 32'h1C, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{"wr_port_in_ro",     1'b1, 1'b1, 32'h04, 32'h0,         1'b1, 32'hFF};
        vecs[13] = '{"rd_port_in",        1'b0, 1'b1, 32'h04, 32'h0,         1'b1, 32'hFF};
        vecs[14] = '{"no_memread",        1'b0, 1'b0, 32'h00, 32'h0,         1'b1, 32'h0};
        vecs[15] = '{"below_window",      1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,  1'b0, 32'h0};
        vecs[16] = '{"wr_count_ro",       1'b1, 1'b1, 32'h14, 32'h5,         1'b1, 32'h100};
        vecs[17] = '{"rd_count_keep",     1'b0, 1'b1, 32'h14, 32'h0,         1'b1, 32'h100};
        vecs[18] = '{"wr_ctrl_clear",     1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 32'h0};
        vecs[19] = '{"rd_low_bits_ign",   1'b0, 1'b1, 32'h03, 32'h0,         1'b1, 32'hDEAD_BEEF};

        reset     = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        PortIn    = 8'hFF;

        // Reset and input synchronizer latency out of reset
        repeat (2) tick();
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_event", {31'b0, Event}, 32'h0);
        chk("rst_select", {31'b0, Select}, 32'h0);
        chk("rst_readdata", ReadData, 32'h0);
        reset = 1'b1;
        rd("rst_status", 32'h08, 32'h0);
        rd("rst_portin_c0", 32'h04, 32'h0);
        tick();
        tick();
        rd("rst_portin_c2", 32'h04, 32'hFF);
        rd("rst_status_c2", 32'h08, 32'h0);
        tick();
        rd("rst_inchg_c3", 32'h08, 32'h1);
        wr(32'h08, 32'h1);
        rd("rst_status_clr", 32'h08, 32'h0);

        foreach (vecs[i]) begin
            Address   = Base + vecs[i].off;
            WriteData = vecs[i].wdata;
            MemWrite  = vecs[i].we;
            MemRead   = vecs[i].re;
            expectVal({vecs[i].name, "_sel"}, {31'b0, vecs[i].expSel});
            expectVal({vecs[i].name, "_rd"}, vecs[i].expRd);
            #1;
            compare({31'b0, Select});
            compare(ReadData);
            tick();
            MemWrite = 1'b0;
            MemRead  = 1'b0;
        end
        chk("portout_pin", PortOut, 32'hDEAD_BEEF);

        // Input change detection and Event latency
        PortIn = 8'h00;
        repeat (4) tick();
        wr(32'h08, 32'h1);
        wr(32'h10, 32'h4);
        rd("in_status_idle", 32'h08, 32'h0);
        PortIn = 8'h5A;
        rd("in_t0", 32'h04, 32'h0);
        tick();
        rd("in_t1", 32'h04, 32'h0);
        tick();
        rd("in_t2", 32'h04, 32'h5A);
        rd("in_st_t2", 32'h08, 32'h0);
        chk("in_ev_t2", {31'b0, Event}, 32'h0);
        tick();
        rd("in_st_t3", 32'h08, 32'h1);
        chk("in_ev_t3", {31'b0, Event}, 32'h0);
        tick();
        chk("in_ev_t4", {31'b0, Event}, 32'h1);

        // Hardware set coinciding with W1C keeps the bit
        PortIn = 8'h33;
        tick();
        tick();
        wr(32'h08, 32'h1);
        rd("in_set_beats_clr", 32'h08, 32'h1);
        wr(32'h08, 32'h1);
        rd("in_w1c", 32'h08, 32'h0);
        wr(32'h10, 32'h0);

        // One-shot timer
        wr(32'h0C, 32'h3);
        wr(32'h10, 32'h9);
        rd("os_cnt_e0", 32'h14, 32'h3);
        tick();
        rd("os_cnt_e1", 32'h14, 32'h2);
        tick();
        rd("os_cnt_e2", 32'h14, 32'h1);
        tick();
        rd("os_cnt_e3", 32'h14, 32'h0);
        rd("os_st_e3", 32'h08, 32'h0);
        tick();
        rd("os_exp_e4", 32'h08, 32'h2);
        rd("os_en_clr", 32'h10, 32'h8);
        chk("os_ev_e4", {31'b0, Event}, 32'h0);
        tick();
        chk("os_ev_e5", {31'b0, Event}, 32'h1);
        rd("os_cnt_hold", 32'h14, 32'h0);
        wr(32'h10, 32'h0);
        wr(32'h08, 32'h2);
        rd("os_st_clr", 32'h08, 32'h0);

        // Auto-reload timer: period N+1
        wr(32'h0C, 32'h4);
        wr(32'h10, 32'h3);
        n = 0;
        for (int p = 0; p < 3; p++) begin
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                Address = Base + 32'h08;
                MemRead = 1'b1;
                #1;
                if (ReadData[1]) begin
                    found = 1'b1;
                end else begin
                    MemRead = 1'b0;
                    tick();
                    n++;
                end
                MemRead = 1'b0;
            end
            chk("auto_period", 32'(n), 32'd5);
            if (p == 0) rd("auto_reload", 32'h14, 32'h4);
            wr(32'h08, 32'h2);
            n = 1;
            rd("auto_w1c", 32'h08, 32'h0);
        end
        wr(32'h10, 32'h0);
        wr(32'h08, 32'h2);

        // Load 0 with AUTO expires every cycle
        wr(32'h0C, 32'h0);
        wr(32'h10, 32'h3);
        tick();
        rd("zero_exp", 32'h08, 32'h2);
        wr(32'h08, 32'h2);
        rd("zero_set_beats_clr", 32'h08, 32'h2);
        wr(32'h10, 32'h0);
        wr(32'h08, 32'h2);
        rd("zero_clr", 32'h08, 32'h0);

        // Reset mid-countdown
        wr(32'h0C, 32'h7);
        wr(32'h10, 32'h1);
        rd("rc_cnt_before", 32'h14, 32'h7);
        PortIn = 8'h00;
        reset  = 1'b0;
        tick();
        reset = 1'b1;
        rd("rc_cnt", 32'h14, 32'h0);
        rd("rc_ctrl", 32'h10, 32'h0);
        rd("rc_load", 32'h0C, 32'h0);
        chk("rc_portout", PortOut, 32'h0);
        repeat (12) tick();
        rd("rc_no_exp", 32'h08, 32'h0);
        chk("rc_event", {31'b0, Event}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
